bundle_accumulator: RTL

//  Majority-vote bundler that sits directly downstream of the permute stage in the HPU datapath.

---
 rtl/bundle_accumulator.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bundle_accumulator.sv
// -----------------------------------------------------------------------------
// bundle_accumulator
// Majority-vote bundler placed after the permute stage. Every accepted beat
// moves one signed saturating counter per hypervector bit up (bit=1) or down
// (bit=0). The last beat of a group arms a one-cycle EMIT state. On the EMIT
// edge each counter is reduced to a majority bit, and a zero counter takes its
// bit from tie_data. The counters are then cleared for the next group.
//
// Ports
//   clk        clock, rising-edge
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort of the current group (no emit)
//   in_valid   in_data carries a beat
//   in_last    marks the final beat of a group (only when accepted)
//   in_data    hypervector beat, DIM+1 bits
//   in_ready   low only during EMIT; depends on state alone
//   tie_data   tie-break bits, sampled on the emit edge
//   out_valid  one-cycle pulse with a new bundle
//   out_data   bundled hypervector, held until the next emit
//   vec_count  beats accepted in the current group, saturating
// -----------------------------------------------------------------------------
module bundle_accumulator #(
    parameter int DIM   = 1023,
    parameter int CNT_W = 8,
    parameter int NUM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [DIM:0]     in_data,
    output logic             in_ready,
    input  logic [DIM:0]     tie_data,
    output logic             out_valid,
    output logic [DIM:0]     out_data,
    output logic [NUM_W-1:0] vec_count
);

    // Symmetric saturation bounds: +(2^(CNT_W-1)-1) and its negation.
    localparam logic signed [CNT_W-1:0] CNT_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] CNT_MIN  = -CNT_MAX;
    localparam logic signed [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic signed [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [NUM_W-1:0]        NUM_ONE  = {{(NUM_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0]        NUM_FULL = {NUM_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t                   state_r;
    logic signed [CNT_W-1:0]  cnt_r [0:DIM];
    logic                     out_valid_r;
    logic [DIM:0]             out_data_r;
    logic [NUM_W-1:0]         vec_count_r;
    logic                     in_ready_s;
    logic                     accept_s;

    // One saturating step of a vote counter.
    function automatic logic signed [CNT_W-1:0] cnt_step(
        input logic signed [CNT_W-1:0] c,
        input logic                    up
    );
        logic signed [CNT_W-1:0] r;
        if (up) begin
            if (c >= CNT_MAX) r = CNT_MAX;
            else              r = c + CNT_ONE;
        end else begin
            if (c <= CNT_MIN) r = CNT_MIN;
            else              r = c - CNT_ONE;
        end
        return r;
    endfunction

    // Majority decision for one bit; an exact tie defers to the tie bit.
    function automatic logic majority(
        input logic signed [CNT_W-1:0] c,
        input logic                    tie
    );
        logic r;
        if (c > CNT_ZERO)      r = 1'b1;
        else if (c < CNT_ZERO) r = 1'b0;
        else                   r = tie;
        return r;
    endfunction

    // Handshake: ready depends on state alone, so it never combinationally follows in_valid.
    always_comb begin
        in_ready_s = 1'b0;
        accept_s   = 1'b0;
        if (state_r != ST_EMIT) in_ready_s = 1'b1;
        else                    in_ready_s = 1'b0;
        accept_s = in_valid & in_ready_s;
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign vec_count = vec_count_r;

    // Group FSM, emit pulse and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            vec_count_r <= {NUM_W{1'b0}};
        end else if (clear) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            vec_count_r <= {NUM_W{1'b0}};
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_ACC: begin
                    if (accept_s) begin
                        if (vec_count_r != NUM_FULL) vec_count_r <= vec_count_r + NUM_ONE;
                        else                         vec_count_r <= vec_count_r;
                        if (in_last) state_r <= ST_EMIT;
                        else         state_r <= ST_ACC;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_EMIT: begin
                    out_valid_r <= 1'b1;
                    vec_count_r <= {NUM_W{1'b0}};
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    vec_count_r <= {NUM_W{1'b0}};
                end
            endcase
        end
    end

    // Per-bit vote counters and the bundled output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r <= {(DIM+1){1'b0}};
            for (int i = 0; i <= DIM; i++) cnt_r[i] <= CNT_ZERO;
        end else if (clear) begin
            for (int i = 0; i <= DIM; i++) cnt_r[i] <= CNT_ZERO;
        end else if (state_r == ST_EMIT) begin
            for (int i = 0; i <= DIM; i++) begin
                out_data_r[i] <= majority(cnt_r[i], tie_data[i]);
                cnt_r[i]      <= CNT_ZERO;
            end
        end else if (accept_s) begin
            for (int i = 0; i <= DIM; i++) cnt_r[i] <= cnt_step(cnt_r[i], in_data[i]);
        end
    end

endmodule
